byte_bus_master: RTL

- Host-side driver for the byte-serial operand/result bus used by our tt_um test harnesses.
- Takes one wide operand word over a valid/ready handshake and writes it into the DUT one byte per cycle, using the byte select on uio bits [LOG2_BYTES_IN-1:0].
- After a settle gap it reads the result back one byte per cycle, using the select on uio bits [4+LOG2_BYTES_OUT-1:4], and presents the reassembled result on a valid/ready output.

---
 rtl/byte_bus_master_if.sv | 33 +++
 rtl/byte_bus_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/byte_bus_master_if.sv
// Bundle of the operand/result handshakes and the byte-serial bus between
// the host-side bus master and the tt_um style DUT harness.
interface byte_bus_master_if #(
  parameter int LOG2_BYTES_IN  = 3,
  parameter int LOG2_BYTES_OUT = 2
);
  localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
  localparam int BYTES_OUT = 1 << LOG2_BYTES_OUT;

  // Both handshakes: a word moves on a rising edge where valid and ready are
  // both high; the producer holds valid and data stable until that edge.
  logic                   op_valid;
  logic                   op_ready;
  logic [BYTES_IN*8-1:0]  op_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [BYTES_OUT*8-1:0] res_data;

  // Byte bus to the DUT: ui_in, uio_in (write idx [3:0], read idx [7:4]), uo_out.
  logic [7:0]             bus_data;
  logic [7:0]             bus_sel;
  logic [7:0]             bus_rd;

  modport master (
    input  op_valid, op_data, res_ready, bus_rd,
    output op_ready, res_valid, res_data, bus_data, bus_sel
  );

  modport slave (
    output op_valid, op_data, res_ready, bus_rd,
    input  op_ready, res_valid, res_data, bus_data, bus_sel
  );
endinterface

// File: rtl/byte_bus_master.sv
// Writes a wide operand into a byte-serial DUT, waits a settle gap, reads the
// result back byte by byte and offers it on a valid/ready output.
module byte_bus_master #(
  parameter int LOG2_BYTES_IN  = 3,
  parameter int LOG2_BYTES_OUT = 2,
  parameter int SETTLE         = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  byte_bus_master_if.master        bus,
  output logic                     busy,
  output logic [2:0]               state_dbg
);
  localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
  localparam int BYTES_OUT = 1 << LOG2_BYTES_OUT;
  localparam logic [3:0] LAST_IN     = 4'(BYTES_IN - 1);
  localparam logic [3:0] LAST_OUT    = 4'(BYTES_OUT - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE - 1);

  if (LOG2_BYTES_IN < 0 || LOG2_BYTES_IN > 4) begin : g_bad_in
    $error("byte_bus_master: LOG2_BYTES_IN must be 0..4");
  end
  if (LOG2_BYTES_OUT < 0 || LOG2_BYTES_OUT > 4) begin : g_bad_out
    $error("byte_bus_master: LOG2_BYTES_OUT must be 0..4");
  end
  if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
    $error("byte_bus_master: SETTLE must be 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_SETTLE = 3'd2,
    S_READ   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [3:0]             cnt_nxt;
  logic [BYTES_IN*8-1:0]  op_q;
  logic [7:0]             bus_data_q;
  logic [7:0]             bus_sel_q;
  logic                   res_valid_q;
  logic [BYTES_OUT*8-1:0] res_data_q;

  assign cnt_nxt = cnt + 4'd1;

  // cnt is the byte index currently on the bus in WRITE/READ and the gap
  // count in SETTLE; bus registers are loaded one edge ahead of their cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      bus_data_q  <= '0;
      bus_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.op_valid) begin
            op_q       <= bus.op_data;
            bus_data_q <= bus.op_data[7:0];
            bus_sel_q  <= 8'h00;
            cnt        <= '0;
            state      <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (cnt == LAST_IN) begin
            cnt   <= '0;
            state <= (SETTLE > 0) ? S_SETTLE : S_READ;
          end else begin
            cnt            <= cnt_nxt;
            bus_data_q     <= 8'(op_q >> (8 * int'(cnt_nxt)));
            bus_sel_q[3:0] <= cnt_nxt;
          end
        end

        S_SETTLE: begin
          bus_sel_q[7:4] <= 4'd0;
          if (cnt == LAST_SETTLE) begin
            cnt   <= '0;
            state <= S_READ;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        S_READ: begin
          for (int j = 0; j < BYTES_OUT; j++) begin
            if (cnt == 4'(j)) res_data_q[8*j +: 8] <= bus.bus_rd;
          end
          if (cnt == LAST_OUT) begin
            res_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt            <= cnt_nxt;
            bus_sel_q[7:4] <= cnt_nxt;
          end
        end

        S_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready  = (state == S_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.bus_data  = bus_data_q;
  assign bus.bus_sel   = bus_sel_q;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;
endmodule
